// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types for the pipeline hazard control unit.
//   hazard_state_t : FSM state encoding (RUN, LU_HOLD, HALTED).
//   latch_ctrl_t   : control bundle for one pipeline latch (stall, flush, bubble).
// Optional build macro used by the top: HAZARD_CTRL_PERF_EN.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_HOLD = 2'd1,
    HALTED  = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic stall;
    logic flush;
    logic bubble;
  } latch_ctrl_t;

  localparam latch_ctrl_t LATCH_IDLE = '{stall: 1'b0, flush: 1'b0, bubble: 1'b0};

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// hazard_ctrl_lu_detect: combinational load-use hazard comparator.
// Ports:
//   ex_dmemREN, ex_regwrite : EX-stage instruction is a load that writes a register
//   ex_wsel                 : EX-stage destination register
//   id_rs, id_rt            : ID-stage source registers
//   id_uses_rt              : ID-stage instruction actually reads rt
//   lu_hit                  : ID needs a value the EX-stage load has not produced yet
module hazard_ctrl_lu_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_dmemREN,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_wsel,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              lu_hit
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_wsel == id_rs);
  assign rt_match = id_uses_rt && (ex_wsel == id_rt);

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign lu_hit = ex_dmemREN && ex_regwrite && (ex_wsel != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control unit driving the IF/ID, ID/EX, EX/MEM and MEM/WB
// latch controls and the PC enable. Arbitrates halt, data-memory wait, taken
// branch/jump, load-use hazard and instruction-fetch wait. Outputs are Mealy
// (registered state plus current inputs).
// Ports:
//   CLK, RST            : clock (rising edge), asynchronous active-high reset
//   ihit, dhit          : instruction / data access complete this cycle
//   mem_dreq, mem_halt  : MEM-stage data request, halt instruction in MEM
//   ex_branch_taken     : EX redirects the PC
//   ex_dmemREN, ex_regwrite, ex_wsel : EX-stage load/destination info
//   id_rs, id_rt, id_uses_rt         : ID-stage source registers
//   pc_en, *_stall, *_flush, idex_bubble : latch and PC controls
//   halted              : sticky halt indication
//   dbg_state, dbg_lu_cnt : FSM state and load-use hold counter
// Optional: define HAZARD_CTRL_PERF_EN to add perf_stall_cycles and
// perf_flush_count saturating counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_dreq,
  input  logic              mem_halt,
  input  logic              ex_branch_taken,
  input  logic              ex_dmemREN,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_wsel,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              pc_en,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              idex_bubble,
  output logic              exmem_stall,
  output logic              exmem_flush,
  output logic              memwb_stall,
  output logic              memwb_flush,
  output logic              halted,
  output hazard_state_t     dbg_state,
  output logic [1:0]        dbg_lu_cnt
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);

  // Remaining hold cycles after the first load-use bubble.
  localparam logic [1:0] LU_INIT = 2'(LU_STALL_CYCLES - 1);

  hazard_state_t state, nxt_state;
  logic [1:0]    lu_cnt, nxt_lu_cnt;
  logic          lu_hit;
  logic          memwait;
  logic          pc_en_c;
  latch_ctrl_t   ifid, idex, exmem, memwb;

  hazard_ctrl_lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
    .ex_dmemREN  (ex_dmemREN),
    .ex_regwrite (ex_regwrite),
    .ex_wsel     (ex_wsel),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .lu_hit      (lu_hit)
  );

  assign memwait = mem_dreq && !dhit;

  always_comb begin
    pc_en_c    = 1'b1;
    ifid       = LATCH_IDLE;
    idex       = LATCH_IDLE;
    exmem      = LATCH_IDLE;
    memwb      = LATCH_IDLE;
    nxt_state  = state;
    nxt_lu_cnt = lu_cnt;

    if (state == HALTED) begin
      pc_en_c     = 1'b0;
      ifid.flush  = 1'b1;
      idex.flush  = 1'b1;
      exmem.flush = 1'b1;
      memwb.flush = 1'b1;
    end else if (memwait) begin
      // Whole pipe freezes; MEM/WB is flushed so the waiting instruction's
      // writeback is not repeated. State and counter hold.
      pc_en_c     = 1'b0;
      ifid.stall  = 1'b1;
      idex.stall  = 1'b1;
      exmem.stall = 1'b1;
      memwb.flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The redirect squashes the stalled ID instruction, so any hold is moot.
      ifid.flush = 1'b1;
      idex.flush = 1'b1;
      nxt_state  = RUN;
      nxt_lu_cnt = 2'd0;
    end else if (state == LU_HOLD || lu_hit) begin
      pc_en_c     = 1'b0;
      ifid.stall  = 1'b1;
      idex.bubble = 1'b1;
      if (state == LU_HOLD) begin
        nxt_lu_cnt = lu_cnt - 2'd1;
        if (lu_cnt == 2'd1) nxt_state = RUN;
      end else if (LU_STALL_CYCLES > 1) begin
        nxt_state  = LU_HOLD;
        nxt_lu_cnt = LU_INIT;
      end
    end else if (!ihit) begin
      pc_en_c    = 1'b0;
      ifid.flush = 1'b1;
    end

    if (state != HALTED && mem_halt && !memwait) begin
      nxt_state  = HALTED;
      nxt_lu_cnt = 2'd0;
    end

    // Reset overrides everything combinationally: flush all latches, hold PC.
    if (RST) begin
      pc_en_c = 1'b0;
      ifid    = '{stall: 1'b0, flush: 1'b1, bubble: 1'b0};
      idex    = '{stall: 1'b0, flush: 1'b1, bubble: 1'b0};
      exmem   = '{stall: 1'b0, flush: 1'b1, bubble: 1'b0};
      memwb   = '{stall: 1'b0, flush: 1'b1, bubble: 1'b0};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= nxt_state;
      lu_cnt <= nxt_lu_cnt;
    end
  end

  assign pc_en       = pc_en_c;
  assign ifid_stall  = ifid.stall;
  assign ifid_flush  = ifid.flush;
  assign idex_stall  = idex.stall;
  assign idex_flush  = idex.flush;
  assign idex_bubble = idex.bubble;
  assign exmem_stall = exmem.stall;
  assign exmem_flush = exmem.flush;
  assign memwb_stall = memwb.stall;
  assign memwb_flush = memwb.flush;
  assign halted      = (state == HALTED) && !RST;
  assign dbg_state   = state;
  assign dbg_lu_cnt  = lu_cnt;

  // Only ID/EX has a bubble input; the other bundles' bubble bits stay zero.
  logic unused_bubbles;
  assign unused_bubbles = ^{ifid.bubble, exmem.bubble, memwb.bubble};

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!pc_en_c && state != HALTED && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ex_branch_taken && !memwait && state != HALTED && perf_flush_count != 32'hFFFF_FFFF)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl. Two instances share the
// inputs: u_dut1 with LU_STALL_CYCLES=1 and u_dut2 with LU_STALL_CYCLES=2.
// Output word compared per instance (15 bits):
//   [14]pc_en [13]ifid_stall [12]ifid_flush [11]idex_stall [10]idex_flush
//   [9]idex_bubble [8]exmem_stall [7]exmem_flush [6]memwb_stall [5]memwb_flush
//   [4]halted [3:2]dbg_state [1:0]dbg_lu_cnt
module tb_hazard_ctrl;

  localparam int W = 15;

  // Control-output patterns (11 bits, order as in the header above).
  localparam logic [10:0] C_NORMAL  = 11'b100_0000_0000; // pc_en only
  localparam logic [10:0] C_LU      = 11'b010_0010_0000; // ifid_stall, idex_bubble
  localparam logic [10:0] C_BRANCH  = 11'b101_0100_0000; // pc_en, ifid_flush, idex_flush
  localparam logic [10:0] C_MEMWAIT = 11'b010_1001_0010; // ifid/idex/exmem stall, memwb_flush
  localparam logic [10:0] C_NOFETCH = 11'b001_0000_0000; // ifid_flush
  localparam logic [10:0] C_HALTED  = 11'b001_0100_1011; // all flushes, halted
  localparam logic [10:0] C_RESET   = 11'b001_0100_1010; // all flushes

  localparam logic [1:0] S_RUN = 2'd0, S_HOLD = 2'd1, S_HALT = 2'd2;

  typedef struct {
    logic       rst, ihit, dhit, dreq, halt, br, ren, rw;
    logic [4:0] wsel, rs, rt;
    logic       uses_rt;
  } in_t;

  typedef struct {
    in_t         in;
    logic [10:0] ctl;
    string       name;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic       ihit, dhit, mem_dreq, mem_halt, ex_branch_taken;
  logic       ex_dmemREN, ex_regwrite, id_uses_rt;
  logic [4:0] ex_wsel, id_rs, id_rt;

  wire [10:0] o1, o2;
  wire [1:0]  s1, s2, c1, c2;
`ifdef HAZARD_CTRL_PERF_EN
  wire [31:0] ps1, pf1, ps2, pf2;
`endif

  hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .mem_halt(mem_halt), .ex_branch_taken(ex_branch_taken),
    .ex_dmemREN(ex_dmemREN), .ex_regwrite(ex_regwrite), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .pc_en(o1[10]), .ifid_stall(o1[9]), .ifid_flush(o1[8]),
    .idex_stall(o1[7]), .idex_flush(o1[6]), .idex_bubble(o1[5]),
    .exmem_stall(o1[4]), .exmem_flush(o1[3]),
    .memwb_stall(o1[2]), .memwb_flush(o1[1]), .halted(o1[0]),
    .dbg_state(s1), .dbg_lu_cnt(c1)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_stall_cycles(ps1), .perf_flush_count(pf1)
`endif
  );

  hazard_ctrl #(.REG_AW(5), .LU_STALL_CYCLES(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .mem_halt(mem_halt), .ex_branch_taken(ex_branch_taken),
    .ex_dmemREN(ex_dmemREN), .ex_regwrite(ex_regwrite), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .pc_en(o2[10]), .ifid_stall(o2[9]), .ifid_flush(o2[8]),
    .idex_stall(o2[7]), .idex_flush(o2[6]), .idex_bubble(o2[5]),
    .exmem_stall(o2[4]), .exmem_flush(o2[3]),
    .memwb_stall(o2[2]), .memwb_flush(o2[1]), .halted(o2[0]),
    .dbg_state(s2), .dbg_lu_cnt(c2)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_stall_cycles(ps2), .perf_flush_count(pf2)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  // Compare on the falling edge, half a cycle after inputs settle.
  always @(negedge CLK) begin
    if (exp_q1.size() > 0) begin
      logic [W-1:0] e1, e2, a1, a2;
      string nm;
      e1 = exp_q1.pop_front();
      e2 = exp_q2.pop_front();
      nm = name_q.pop_front();
      a1 = {o1, s1, c1};
      a2 = {o2, s2, c2};
      checks++;
      if (a1 !== e1) begin
        errors++;
        $display("FAIL %s lu1: got %b expected %b", nm, a1, e1);
      end
      checks++;
      if (a2 !== e2) begin
        errors++;
        $display("FAIL %s lu2: got %b expected %b", nm, a2, e2);
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic in_t idle();
    in_t v;
    v.rst = 1'b0; v.ihit = 1'b1; v.dhit = 1'b1; v.dreq = 1'b0; v.halt = 1'b0;
    v.br = 1'b0; v.ren = 1'b0; v.rw = 1'b0;
    v.wsel = 5'd0; v.rs = 5'd0; v.rt = 5'd0; v.uses_rt = 1'b0;
    return v;
  endfunction

  function automatic in_t ld(input logic [4:0] w, input logic [4:0] rs,
                             input logic [4:0] rt, input logic u);
    in_t v;
    v = idle();
    v.ren = 1'b1; v.rw = 1'b1; v.wsel = w; v.rs = rs; v.rt = rt; v.uses_rt = u;
    return v;
  endfunction

  function automatic in_t with_rst();
    in_t v;
    v = idle();
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic in_t memw(input in_t b);
    in_t v;
    v = b;
    v.dreq = 1'b1; v.dhit = 1'b0;
    return v;
  endfunction

  function automatic logic [W-1:0] ex(input logic [10:0] c, input logic [1:0] s,
                                      input logic [1:0] n);
    return {c, s, n};
  endfunction

  function automatic vec_t mkv(input in_t i, input logic [10:0] c, input string n);
    vec_t v;
    v.in = i; v.ctl = c; v.name = n;
    return v;
  endfunction

  // One cycle: drive just after the rising edge and queue the expectation.
  task automatic step(input in_t v, input logic [W-1:0] e1, input logic [W-1:0] e2,
                      input string nm);
    @(posedge CLK);
    #1;
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_dreq = v.dreq; mem_halt = v.halt;
    ex_branch_taken = v.br; ex_dmemREN = v.ren; ex_regwrite = v.rw;
    ex_wsel = v.wsel; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
    exp_q1.push_back(e1);
    exp_q2.push_back(e2);
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    step(with_rst(), ex(C_RESET, S_RUN, 2'd0), ex(C_RESET, S_RUN, 2'd0), "reset");
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[16];

  initial begin
    in_t t;
    ihit = 1'b1; dhit = 1'b1; mem_dreq = 1'b0; mem_halt = 1'b0; ex_branch_taken = 1'b0;
    ex_dmemREN = 1'b0; ex_regwrite = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0;

    tbl[0] = mkv(idle(), C_NORMAL, "idle");
    tbl[1] = mkv(ld(5'd5, 5'd5, 5'd0, 1'b0), C_LU, "lu_rs");
    tbl[2] = mkv(ld(5'd7, 5'd3, 5'd7, 1'b1), C_LU, "lu_rt");
    tbl[3] = mkv(ld(5'd7, 5'd3, 5'd7, 1'b0), C_NORMAL, "rt_not_used");
    tbl[4] = mkv(ld(5'd0, 5'd0, 5'd0, 1'b1), C_NORMAL, "reg0_excluded");
    t = ld(5'd9, 5'd9, 5'd0, 1'b0); t.rw = 1'b0;
    tbl[5] = mkv(t, C_NORMAL, "load_no_regwrite");
    t = ld(5'd9, 5'd9, 5'd0, 1'b0); t.ren = 1'b0;
    tbl[6] = mkv(t, C_NORMAL, "alu_op_forwarded");
    t = ld(5'd5, 5'd5, 5'd0, 1'b0); t.br = 1'b1;
    tbl[7] = mkv(t, C_BRANCH, "branch_over_lu");
    t.br = 1'b1;
    tbl[8] = mkv(memw(t), C_MEMWAIT, "memwait_over_all");
    t = idle(); t.dreq = 1'b1;
    tbl[9] = mkv(t, C_NORMAL, "dreq_with_dhit");
    t = idle(); t.ihit = 1'b0;
    tbl[10] = mkv(t, C_NOFETCH, "no_ihit");
    t = ld(5'd4, 5'd4, 5'd0, 1'b0); t.ihit = 1'b0;
    tbl[11] = mkv(t, C_LU, "lu_over_no_ihit");
    t = idle(); t.ihit = 1'b0; t.br = 1'b1;
    tbl[12] = mkv(t, C_BRANCH, "branch_over_no_ihit");
    t = idle(); t.halt = 1'b1;
    tbl[13] = mkv(t, C_NORMAL, "halt_entry_cycle");
    t = memw(ld(5'd5, 5'd5, 5'd0, 1'b0)); t.rst = 1'b1;
    tbl[14] = mkv(t, C_RESET, "reset_overrides");
    tbl[15] = mkv(ld(5'd31, 5'd31, 5'd31, 1'b1), C_LU, "lu_reg31");

    for (int i = 0; i < 16; i++) begin
      do_reset();
      step(tbl[i].in, ex(tbl[i].ctl, S_RUN, 2'd0), ex(tbl[i].ctl, S_RUN, 2'd0), tbl[i].name);
    end

    // Load-use: one bubble with LU=1, two with LU=2, then normal.
    do_reset();
    step(ld(5'd5, 5'd5, 5'd0, 1'b0), ex(C_LU, S_RUN, 2'd0), ex(C_LU, S_RUN, 2'd0), "lu_seq_c0");
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_LU, S_HOLD, 2'd1), "lu_seq_c1");
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "lu_seq_c2");

    // Memwait in the middle of the hold: frozen, counter unchanged.
    do_reset();
    step(ld(5'd5, 5'd5, 5'd0, 1'b0), ex(C_LU, S_RUN, 2'd0), ex(C_LU, S_RUN, 2'd0), "lu_mw_c0");
    for (int i = 0; i < 3; i++)
      step(memw(idle()), ex(C_MEMWAIT, S_RUN, 2'd0), ex(C_MEMWAIT, S_HOLD, 2'd1), "lu_mw_wait");
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_LU, S_HOLD, 2'd1), "lu_mw_resume");
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "lu_mw_done");

    // Branch during the hold cancels it.
    do_reset();
    step(ld(5'd6, 5'd6, 5'd0, 1'b0), ex(C_LU, S_RUN, 2'd0), ex(C_LU, S_RUN, 2'd0), "br_hold_c0");
    t = idle(); t.br = 1'b1;
    step(t, ex(C_BRANCH, S_RUN, 2'd0), ex(C_BRANCH, S_HOLD, 2'd1), "br_hold_c1");
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "br_hold_c2");

    // Four cycles of data-memory wait, advance on the fifth.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(memw(idle()), ex(C_MEMWAIT, S_RUN, 2'd0), ex(C_MEMWAIT, S_RUN, 2'd0), "mw4_wait");
    t = idle(); t.dreq = 1'b1;
    step(t, ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "mw4_done");

    // Halt is masked by memwait, then taken; only reset leaves HALTED.
    do_reset();
    t = idle(); t.halt = 1'b1;
    step(memw(t), ex(C_MEMWAIT, S_RUN, 2'd0), ex(C_MEMWAIT, S_RUN, 2'd0), "halt_masked");
    step(t, ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "halt_entry");
    step(idle(), ex(C_HALTED, S_HALT, 2'd0), ex(C_HALTED, S_HALT, 2'd0), "halted_c1");
    t = memw(ld(5'd5, 5'd5, 5'd0, 1'b0)); t.br = 1'b1; t.ihit = 1'b0;
    step(t, ex(C_HALTED, S_HALT, 2'd0), ex(C_HALTED, S_HALT, 2'd0), "halted_sticky");
    do_reset();
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "halt_cleared");

    // Reset mid-hold: no residual stall.
    step(ld(5'd2, 5'd2, 5'd0, 1'b0), ex(C_LU, S_RUN, 2'd0), ex(C_LU, S_RUN, 2'd0), "rst_hold_c0");
    do_reset();
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "rst_hold_after");

    // Reset mid-memwait.
    step(memw(idle()), ex(C_MEMWAIT, S_RUN, 2'd0), ex(C_MEMWAIT, S_RUN, 2'd0), "rst_mw_c0");
    do_reset();
    step(idle(), ex(C_NORMAL, S_RUN, 2'd0), ex(C_NORMAL, S_RUN, 2'd0), "rst_mw_after");

    // Randomised idle/no-fetch cycles with no hazard sources.
    for (int i = 0; i < 20; i++) begin
      t = idle();
      t.ihit = 1'(($urandom_range(0, 3) != 0));
      t.rs = 5'($urandom_range(1, 31));
      t.rt = 5'($urandom_range(1, 31));
      t.wsel = t.rs;
      t.uses_rt = 1'($urandom_range(0, 1));
      step(t, ex(t.ihit ? C_NORMAL : C_NOFETCH, S_RUN, 2'd0),
              ex(t.ihit ? C_NORMAL : C_NOFETCH, S_RUN, 2'd0), "rand_nohazard");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5; i++) begin
      if (exp_q1.size() == 0) break;
      @(negedge CLK);
      #1;
    end
    if (exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q1.size());
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall/flush/bubble inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC enable.
- Arbitrates four conditions: data-memory wait, taken branch/jump redirect, load-use hazard, and halt.
- Small registered FSM plus a load-use hold counter; outputs are Mealy (registered state plus current inputs).

Parameters:
- REG_AW, 5, register-address width.
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with forwarding, 2 without; legal range 1..3).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dreq  in  1  MEM-stage instruction has dmemREN or dmemWEN asserted.
- mem_halt  in  1  halt instruction is in MEM.
- ex_branch_taken  in  1  EX resolved a taken branch or jump; PC loads the target.
- ex_dmemREN  in  1  EX-stage instruction is a load.
- ex_regwrite  in  1  EX-stage instruction writes a register.
- ex_wsel  in  REG_AW  EX-stage destination register.
- id_rs  in  REG_AW  ID-stage source register rs.
- id_rt  in  REG_AW  ID-stage source register rt.
- id_uses_rt  in  1  ID instruction reads rt.
- pc_en  out  1  PC register update enable.
- ifid_stall, ifid_flush  out  1 each  IF/ID latch controls.
- idex_stall, idex_flush, idex_bubble  out  1 each  ID/EX latch controls.
- exmem_stall, exmem_flush  out  1 each  EX/MEM latch controls.
- memwb_stall, memwb_flush  out  1 each  MEM/WB latch controls.
- halted  out  1  sticky halt indication.

Behaviour:
- States: RUN, LU_HOLD, HALTED. Registers: state, lu_cnt (2 bits).
- While RST is high: state=RUN, lu_cnt=0. Outputs forced: pc_en=0, every *_flush=1, every stall/bubble=0, halted=0.
- Conditions:
  - memwait = mem_dreq & ~dhit.
  - lu_hit = ex_dmemREN & ex_regwrite & (ex_wsel!=0) & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- Priority (highest first): HALTED > memwait > ex_branch_taken > load-use (lu_hit or LU_HOLD) > ~ihit > normal.
- HALTED: pc_en=0; ifid_flush, idex_flush, exmem_flush, memwb_flush=1; halted=1. Only RST exits.
- memwait: pc_en=0; ifid_stall, idex_stall, exmem_stall=1; memwb_flush=1 (no duplicate writeback). State and lu_cnt frozen.
- branch: pc_en=1; ifid_flush=1; idex_flush=1. Any pending LU_HOLD is cancelled: next state=RUN, lu_cnt=0.
- load-use, first cycle (RUN & lu_hit): pc_en=0; ifid_stall=1; idex_bubble=1.
  - If LU_STALL_CYCLES>1: next state=LU_HOLD, lu_cnt=LU_STALL_CYCLES-1.
- LU_HOLD: same outputs as the load-use first cycle. lu_cnt decrements each non-memwait cycle; on the cycle lu_cnt==1, next state=RUN.
- ~ihit (otherwise normal): pc_en=0; ifid_flush=1; all other latches advance.
- normal: pc_en=1; all stalls and flushes 0.
- Halt entry: mem_halt & ~memwait -> next state=HALTED; halted rises the following cycle.
- The unit never asserts stall and flush on the same latch in the same cycle.
- Reset asserted mid-LU_HOLD or mid-memwait: immediate return to RUN, no residual stall.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both cleared by RST.
  - perf_stall_cycles increments every cycle pc_en=0 and not HALTED.
  - perf_flush_count increments once per ex_branch_taken cycle that is not masked by memwait or HALTED.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gains:
  - hazard_state_t enum {RUN, LU_HOLD, HALTED}.
  - struct latch_ctrl_t {stall, flush, bubble}, so each latch control group is a single typed bundle.
- Sub-module: hazard_ctrl_lu_detect (combinational lu_hit comparator), instantiated once.

Test Plan:
- ex_dmemREN=1, ex_regwrite=1, ex_wsel=5, id_rs=5, LU_STALL_CYCLES=1 -> one cycle with pc_en=0, ifid_stall=1, idex_bubble=1; next cycle normal.
- Same stimulus with LU_STALL_CYCLES=2 and memwait raised for 3 cycles in the middle -> 2 bubble cycles total, freeze during the wait, lu_cnt unchanged across it.
- ex_wsel=0, id_rs=0, load in EX -> no stall (register 0 excluded).
- ex_branch_taken=1 together with lu_hit=1 -> pc_en=1, ifid_flush=1, idex_flush=1, no bubble; a branch arriving during LU_HOLD cancels the hold (state=RUN next cycle).
- mem_dreq=1, dhit=0 for 4 cycles, then dhit=1 -> 4 cycles of pc_en=0 with exmem_stall=1 and memwb_flush=1; advance on the 5th.
- mem_halt=1 with no memwait -> halted=1 next cycle and all flushes held; RST pulse returns to RUN with halted=0.
